// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, ALU funct3 codes and forwarding-select encoding.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;
  function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return we && rd != '0 && rd == rs;
  endfunction
endpackage

// File: rtl/forward_mux.sv
// forward_mux: picks the freshest value of one source register, EX/MEM before MEM/WB.
module forward_mux import riscv_pkg::*; #(
  parameter int W = riscv_pkg::XLEN
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [W-1:0]      rs_val,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [W-1:0]      exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [W-1:0]      memwb_result,
  output logic [W-1:0]      fwd_data
);
  fwd_sel_e sel;
  always_comb begin
    sel = fwd_hit(exmem_reg_write, exmem_rd, rs_addr) ? FWD_EXMEM :
          fwd_hit(memwb_reg_write, memwb_rd, rs_addr) ? FWD_MEMWB : FWD_NONE;
    fwd_data = sel == FWD_EXMEM ? exmem_result : sel == FWD_MEMWB ? memwb_result : rs_val;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush and operand forwarding.
module id_ex_stage import riscv_pkg::*; #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      funct3,
  input  logic            funct7_bit5,
  input  logic            alu_src_imm,
  input  logic            alu_src_pc,
  input  logic            uses_rs2,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            flush,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      funct3_q,
  output logic            funct7_bit5_q,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_q,
  output logic            reg_write_q,
  output logic            mem_read_q,
  output logic            mem_write_q,
  output logic [XLEN-1:0] pc_q
);
  logic            hazard, cap;
  logic            valid_q, valid_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d, pc_d;
  logic [2:0]      funct3_d;
  logic            funct7_bit5_d, src_imm_q, src_imm_d, src_pc_q, src_pc_d;
  logic            regw_q, regw_d, mrd_q, mrd_d, mwr_q, mwr_d;
  logic [XLEN-1:0] fwd1, fwd2;
  always_comb begin
    hazard = in_valid && valid_q && mrd_q && rd_q != '0 &&
             (rs1_addr == rd_q || (uses_rs2 && rs2_addr == rd_q));
    in_ready = (!valid_q || out_ready) && !hazard && !flush;
    cap = in_valid && in_ready;
    valid_d = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : valid_q;
    // register-file write in the same cycle as the read is taken from MEM/WB
    rs1_val_d = !cap ? rs1_val_q : fwd_hit(memwb_reg_write, memwb_rd, rs1_addr) ? memwb_result : rs1_data;
    rs2_val_d = !cap ? rs2_val_q : fwd_hit(memwb_reg_write, memwb_rd, rs2_addr) ? memwb_result : rs2_data;
    rs1_addr_d = cap ? rs1_addr : rs1_addr_q;
    rs2_addr_d = cap ? rs2_addr : rs2_addr_q;
    rd_d = cap ? rd_addr : rd_q;
    imm_d = cap ? imm : imm_q;
    pc_d = cap ? pc : pc_q;
    funct3_d = cap ? funct3 : funct3_q;
    funct7_bit5_d = cap ? funct7_bit5 : funct7_bit5_q;
    src_imm_d = cap ? alu_src_imm : src_imm_q;
    src_pc_d = cap ? alu_src_pc : src_pc_q;
    regw_d = cap ? reg_write : regw_q;
    mrd_d = cap ? mem_read : mrd_q;
    mwr_d = cap ? mem_write : mwr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
      funct3_q <= '0;
      funct7_bit5_q <= 1'b0;
      src_imm_q <= 1'b0;
      src_pc_q <= 1'b0;
      regw_q <= 1'b0;
      mrd_q <= 1'b0;
      mwr_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_q <= rd_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q <= imm_d;
      pc_q <= pc_d;
      funct3_q <= funct3_d;
      funct7_bit5_q <= funct7_bit5_d;
      src_imm_q <= src_imm_d;
      src_pc_q <= src_pc_d;
      regw_q <= regw_d;
      mrd_q <= mrd_d;
      mwr_q <= mwr_d;
    end
  end
  forward_mux #(.W(XLEN)) u_fwd1 (
    .rs_addr(rs1_addr_q), .rs_val(rs1_val_q),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .fwd_data(fwd1)
  );
  forward_mux #(.W(XLEN)) u_fwd2 (
    .rs_addr(rs2_addr_q), .rs_val(rs2_val_q),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .fwd_data(fwd2)
  );
  assign out_valid = valid_q;
  assign reg_write_q = regw_q && valid_q;
  assign mem_read_q = mrd_q && valid_q;
  assign mem_write_q = mwr_q && valid_q;
  assign operand1 = src_pc_q ? pc_q : fwd1;
  assign operand2 = src_imm_q ? imm_q : fwd2;
  assign store_data = fwd2;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed per-feature tests for id_ex_stage.
module tb_id_ex_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
  logic [2:0] funct3 = '0;
  logic funct7_bit5 = 1'b0, alu_src_imm = 1'b0, alu_src_pc = 1'b0, uses_rs2 = 1'b0;
  logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0;
  logic [4:0] exmem_rd = '0, memwb_rd = '0;
  logic exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [31:0] exmem_result = '0, memwb_result = '0;
  logic out_valid, out_ready = 1'b1;
  logic [2:0] funct3_q;
  logic funct7_bit5_q, reg_write_q, mem_read_q, mem_write_q;
  logic [31:0] operand1, operand2, store_data, pc_q;
  logic [4:0] rd_q;
  int checks = 0, errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .funct3(funct3), .funct7_bit5(funct7_bit5), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
    .uses_rs2(uses_rs2), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .flush(flush), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready), .funct3_q(funct3_q), .funct7_bit5_q(funct7_bit5_q),
    .operand1(operand1), .operand2(operand2), .store_data(store_data), .rd_q(rd_q),
    .reg_write_q(reg_write_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q), .pc_q(pc_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rs1_data = 0; rs2_data = 0;
    imm = 0; pc = 0; funct3 = 0; funct7_bit5 = 0; alu_src_imm = 0; alu_src_pc = 0; uses_rs2 = 0;
    reg_write = 0; mem_read = 0; mem_write = 0; flush = 0; out_ready = 1;
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0; memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic present(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1; rs1_addr = r1; rs2_addr = r2; rd_addr = rd; rs1_data = d1; rs2_data = d2;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    checks++; if (operand1 !== 32'h0) begin errors++; $display("FAIL reset_op1 got %h exp 0", operand1); end
    checks++; if (operand2 !== 32'h0) begin errors++; $display("FAIL reset_op2 got %h exp 0", operand2); end
    checks++; if (store_data !== 32'h0) begin errors++; $display("FAIL reset_store got %h exp 0", store_data); end
  endtask

  task automatic test_add();
    idle(); present(5'd1, 5'd2, 5'd3, 32'd5, 32'd7); uses_rs2 = 1; reg_write = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %0h exp 1", in_ready); end
    tick(); idle(); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0h exp 1", out_valid); end
    checks++; if (operand1 !== 32'd5) begin errors++; $display("FAIL add_op1 got %h exp 5", operand1); end
    checks++; if (operand2 !== 32'd7) begin errors++; $display("FAIL add_op2 got %h exp 7", operand2); end
    checks++; if (rd_q !== 5'd3) begin errors++; $display("FAIL add_rd got %0d exp 3", rd_q); end
    checks++; if (reg_write_q !== 1'b1) begin errors++; $display("FAIL add_regw got %0h exp 1", reg_write_q); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %0h exp 0", out_valid); end
    checks++; if (reg_write_q !== 1'b0) begin errors++; $display("FAIL add_regw_masked got %0h exp 0", reg_write_q); end
  endtask

  task automatic test_imm_pc();
    idle(); present(5'd1, 5'd2, 5'd4, 32'h11, 32'h9); alu_src_imm = 1; alu_src_pc = 1;
    imm = 32'h100; pc = 32'h40; funct3 = 3'b111; funct7_bit5 = 1; mem_write = 1; uses_rs2 = 1;
    tick(); idle(); out_ready = 0; #1;
    checks++; if (operand1 !== 32'h40) begin errors++; $display("FAIL pc_op1 got %h exp 40", operand1); end
    checks++; if (operand2 !== 32'h100) begin errors++; $display("FAIL imm_op2 got %h exp 100", operand2); end
    checks++; if (store_data !== 32'h9) begin errors++; $display("FAIL imm_store got %h exp 9", store_data); end
    checks++; if (pc_q !== 32'h40) begin errors++; $display("FAIL pc_q got %h exp 40", pc_q); end
    checks++; if ({funct3_q, funct7_bit5_q} !== 4'b1111) begin errors++; $display("FAIL funct_q got %h exp f", {funct3_q, funct7_bit5_q}); end
    checks++; if (mem_write_q !== 1'b1) begin errors++; $display("FAIL mem_write_q got %0h exp 1", mem_write_q); end
    out_ready = 1; tick();
    // write-through: MEM/WB result replaces stale register-file read at capture
    present(5'd1, 5'd2, 5'd4, 32'h11, 32'h22); memwb_rd = 5'd1; memwb_reg_write = 1; memwb_result = 32'h55;
    tick(); idle(); out_ready = 0; #1;
    checks++; if (operand1 !== 32'h55) begin errors++; $display("FAIL writethrough_op1 got %h exp 55", operand1); end
    checks++; if (operand2 !== 32'h22) begin errors++; $display("FAIL writethrough_op2 got %h exp 22", operand2); end
    out_ready = 1; tick();
  endtask

  task automatic test_forward();
    idle(); present(5'd4, 5'd0, 5'd6, 32'h99, 32'h0); tick(); idle(); out_ready = 0;
    exmem_rd = 5'd4; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd = 5'd4; memwb_reg_write = 1; memwb_result = 32'h20; #1;
    checks++; if (operand1 !== 32'h10) begin errors++; $display("FAIL fwd_exmem got %h exp 10", operand1); end
    checks++; if (operand2 !== 32'h0) begin errors++; $display("FAIL fwd_x0 got %h exp 0", operand2); end
    exmem_rd = 5'd0; #1;
    checks++; if (operand1 !== 32'h20) begin errors++; $display("FAIL fwd_memwb got %h exp 20", operand1); end
    memwb_reg_write = 0; exmem_rd = 5'd4; exmem_reg_write = 0; #1;
    checks++; if (operand1 !== 32'h99) begin errors++; $display("FAIL fwd_none got %h exp 99", operand1); end
    idle(); tick();
  endtask

  task automatic test_hazard();
    idle(); present(5'd1, 5'd0, 5'd5, 32'h0, 32'h0); mem_read = 1; reg_write = 1; tick();
    idle(); present(5'd5, 5'd0, 5'd6, 32'h77, 32'h0); #1;
    checks++; if (mem_read_q !== 1'b1) begin errors++; $display("FAIL hz_mem_read_q got %0h exp 1", mem_read_q); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hz_in_ready got %0h exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_bubble got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hz_ready_after got %0h exp 1", in_ready); end
    tick(); idle(); #1;
    checks++; if (out_valid !== 1'b1 || rd_q !== 5'd6) begin errors++; $display("FAIL hz_capture got valid=%0h rd=%0d exp 1/6", out_valid, rd_q); end
    checks++; if (operand1 !== 32'h77) begin errors++; $display("FAIL hz_op1 got %h exp 77", operand1); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(); present(5'd1, 5'd0, 5'd7, 32'hA1, 32'h0); tick();
    present(5'd2, 5'd0, 5'd8, 32'hB2, 32'h0); out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0h exp 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || rd_q !== 5'd7 || operand1 !== 32'hA1) begin errors++; $display("FAIL stall_hold[%0d] got valid=%0h rd=%0d op1=%h exp 1/7/a1", i, out_valid, rd_q, operand1); end
      tick();
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %0h exp 1", in_ready); end
    tick(); idle(); #1;
    checks++; if (out_valid !== 1'b1 || rd_q !== 5'd8 || operand1 !== 32'hB2) begin errors++; $display("FAIL b2b_capture got valid=%0h rd=%0d op1=%h exp 1/8/b2", out_valid, rd_q, operand1); end
    tick();
  endtask

  task automatic test_flush();
    idle(); present(5'd1, 5'd0, 5'd9, 32'h1, 32'h0); reg_write = 1; tick();
    present(5'd2, 5'd0, 5'd10, 32'h2, 32'h0); flush = 1; out_ready = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0h exp 0", in_ready); end
    tick(); idle(); out_ready = 0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", out_valid); end
    checks++; if (reg_write_q !== 1'b0) begin errors++; $display("FAIL flush_regw got %0h exp 0", reg_write_q); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture got %0h exp 0", out_valid); end
    idle();
  endtask

  task automatic test_reset_stall();
    idle(); present(5'd1, 5'd0, 5'd5, 32'h3, 32'h4); mem_read = 1; reg_write = 1; imm = 32'h8; pc = 32'h20; funct3 = 3'b010; tick();
    idle(); present(5'd5, 5'd0, 5'd6, 32'h0, 32'h0); out_ready = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_in_ready got %0h exp 0", in_ready); end
    rst = 1; tick(); rst = 0; idle(); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_hs got valid=%0h ready=%0h exp 0/1", out_valid, in_ready); end
    checks++; if (operand1 !== 0 || operand2 !== 0 || store_data !== 0 || pc_q !== 0) begin errors++; $display("FAIL rst_stall_data got %h %h %h %h exp 0", operand1, operand2, store_data, pc_q); end
    checks++; if (rd_q !== 0 || funct3_q !== 0 || mem_read_q !== 0 || reg_write_q !== 0) begin errors++; $display("FAIL rst_stall_ctrl got rd=%0d f3=%0d mr=%0h rw=%0h exp 0", rd_q, funct3_q, mem_read_q, reg_write_q); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm_pc();
    test_forward();
    test_hazard();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width of register data, immediate, PC and results.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  decode stage presents a valid instruction.
REQ-005 in_ready  out  1  stage can accept the presented instruction this cycle.
REQ-006 rs1_addr, rs2_addr, rd_addr  in  5 each  register specifiers.
REQ-007 rs1_data, rs2_data  in  XLEN each  register-file read data.
REQ-008 imm, pc  in  XLEN each  decoded immediate and instruction address.
REQ-009 funct3  in  3; funct7_bit5  in  1  ALU operation select.
REQ-010 alu_src_imm, alu_src_pc, uses_rs2, reg_write, mem_read, mem_write  in  1 each  decode controls.
REQ-011 flush  in  1  kill the held instruction and the presented one.
REQ-012 exmem_rd  in  5; exmem_reg_write  in  1; exmem_result  in  XLEN  EX/MEM forwarding source.
REQ-013 memwb_rd  in  5; memwb_reg_write  in  1; memwb_result  in  XLEN  MEM/WB forwarding source.
REQ-014 out_valid  out  1; out_ready  in  1  handshake toward execute/memory.
REQ-015 funct3_q  out  3; funct7_bit5_q  out  1  registered ALU select.
REQ-016 operand1, operand2  out  XLEN each  ALU operands after forwarding and source select.
REQ-017 store_data  out  XLEN; rd_q  out  5; reg_write_q, mem_read_q, mem_write_q  out  1 each; pc_q  out  XLEN.

Function
REQ-018 Capture: in_valid && in_ready loads all payload into the register next edge; out_valid becomes 1.
REQ-019 Advance: out_valid && out_ready without capture clears out_valid next edge.
REQ-020 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-021 hazard = in_valid && out_valid && mem_read_q && rd_q!=0 && (rs1_addr==rd_q || (uses_rs2 && rs2_addr==rd_q)).
REQ-022 On hazard with out_ready=1, out_valid becomes 0 next edge (one bubble); with out_ready=0, register holds.
REQ-023 Write-through at capture: if memwb_reg_write && memwb_rd!=0 && memwb_rd==rsN_addr, capture memwb_result instead of rsN_data.
REQ-024 Forwarding is combinational on held contents: rsN matches exmem_rd (nonzero, exmem_reg_write) -> exmem_result; else matches memwb_rd likewise -> memwb_result; else held rsN value.
REQ-025 EX/MEM forwarding has priority over MEM/WB; register x0 is never forwarded.
REQ-026 operand1 = alu_src_pc ? pc_q : forwarded rs1; operand2 = alu_src_imm ? imm_q : forwarded rs2; store_data = forwarded rs2.
REQ-027 flush: out_valid becomes 0 next edge, no capture that cycle, regardless of out_ready and hazard; payload registers may keep stale values.
REQ-028 While out_valid=0, reg_write_q, mem_read_q, mem_write_q read as 0.
REQ-029 Latency: one cycle from capture to out_valid; full throughput when out_ready=1 and no hazard.

Reset
REQ-030 rst has priority over flush and capture; next edge out_valid=0, all payload and control registers 0.
REQ-031 Out of reset, in_ready=1 (given flush=0) and operand1/operand2/store_data=0 with no forwarding match.
REQ-032 rst asserted mid-stall discards the held instruction; no output handshake completes that cycle.

Structure
REQ-033 Shared package riscv_pkg holds XLEN, register-address width, funct3 operation constants and the forward-select encoding (NONE, EXMEM, MEMWB).
REQ-034 One sub-module, forward_mux, instantiated for rs1 and for rs2, implements REQ-024/025.
REQ-035 Outputs funct3_q, funct7_bit5_q, operand1, operand2 connect directly to the ALU ports of matching meaning.

Verification
REQ-036 Reset then add x3=x1+x2 (rs1_data=5, rs2_data=7, funct3=000) with out_ready=1 -> next cycle out_valid=1, operand1=5, operand2=7.
REQ-037 Held instr rs1=x4, exmem_rd=4 result 0x10, memwb_rd=4 result 0x20 -> operand1=0x10; exmem_rd=0 instead -> 0x20.
REQ-038 Load to x5 held (mem_read_q=1), next instr rs1=x5 -> in_ready=0 one cycle, one bubble (out_valid=0), then capture.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> new instruction captured same edge as advance.
REQ-040 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, reg_write_q=0, nothing captured.
REQ-041 rst asserted during hazard stall -> next cycle out_valid=0, in_ready=1, all outputs 0.
